// File: rtl/seq_add_sub.sv
// Chunk-serial two's-complement adder/subtractor with valid/ready handshakes.
// Optional signed saturation of the result: define SEQ_ADD_SUB_SAT_EN.
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, res_q, res_d, out_q, out_d;
  logic               carry_q, cout_q, ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CHUNK:0]     chunk_sum;
  logic               accept, last_chunk;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign accept     = in_valid & in_ready;
  assign last_chunk = (idx_q == IDX_W'(N - 1));
  assign out        = out_q;
  assign cout       = cout_q;
  assign ovf        = ovf_q;

  // One CHUNK-wide slice of the ripple per cycle; the top bit is the carry into the next slice.
  assign chunk_sum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
                   + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    res_d = res_q;
    res_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SEQ_ADD_SUB_SAT_EN
    if (ovf_d) begin
      out_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      out_d = res_d;
    end
`else
    out_d = res_d;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)     state_d = CALC;
      CALC:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: operand registers are reset too; it keeps the datapath deterministic after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= in1;
      b_q     <= in2 ^ {WIDTH{sub}};
      carry_q <= sub;
      idx_q   <= '0;
    end else if (state_q == CALC) begin
      res_q   <= res_d;
      carry_q <= chunk_sum[CHUNK];
      idx_q   <= last_chunk ? '0 : idx_q + IDX_W'(1);
      // Visible outputs only move on the edge that enters DONE.
      if (last_chunk) begin
        out_q  <= out_d;
        cout_q <= chunk_sum[CHUNK];
        ovf_q  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Self-checking bench for seq_add_sub (WIDTH=16, CHUNK=4): directed vectors,
// handshake/reset sequences and random operations against an arithmetic model.
module tb_seq_add_sub;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;
  localparam int LIMIT = 50;
`ifdef SEQ_ADD_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] in1, in2, out;

  int checks = 0;
  int errors = 0;

  seq_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        s;
    logic [15:0] o, o_sat;
    logic        co, ov;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic straight from the operation's meaning.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] o, output logic co, output logic ov);
    int sa, sb, r, ua, ub;
    sa = int'(signed'(a));
    sb = int'(signed'(b));
    ua = int'(a);
    ub = int'(b);
    r  = s ? sa - sb : sa + sb;
    ov = (r > 32767) || (r < -32768);
    co = s ? (ua >= ub) : ((ua + ub) > 65535);
    o  = r[15:0];
    if (SAT && ov) o = (r > 0) ? 16'h7FFF : 16'h8000;
  endfunction

  // Full transaction: accept, count cycles to out_valid, capture, handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output logic [15:0] o, output logic co, output logic ov, output int lat);
    @(negedge clk);
    in1 = a; in2 = b; sub = s; in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = 16'($urandom); in2 = 16'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    o = out; co = cout; ov = ovf;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_handshake", in_ready, 1'b1);
    check("out_valid_after_handshake", out_valid, 1'b0);
  endtask

  initial begin
    logic [15:0] o, eo, prev, held;
    logic        co, ov, eco, eov;
    int          lat;

    vecs[0] = '{a:16'h00FF, b:16'h0F01, s:1'b0, o:16'h1000, o_sat:16'h1000, co:1'b0, ov:1'b0};
    vecs[1] = '{a:16'hFFFF, b:16'h0001, s:1'b0, o:16'h0000, o_sat:16'h0000, co:1'b1, ov:1'b0};
    vecs[2] = '{a:16'h7FFF, b:16'h0001, s:1'b0, o:16'h8000, o_sat:16'h7FFF, co:1'b0, ov:1'b1};
    vecs[3] = '{a:16'h0005, b:16'h0007, s:1'b1, o:16'hFFFE, o_sat:16'hFFFE, co:1'b0, ov:1'b0};
    vecs[4] = '{a:16'h8000, b:16'h0001, s:1'b1, o:16'h7FFF, o_sat:16'h8000, co:1'b1, ov:1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; sub = 1'b0;
    #2;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out", out, 16'h0);
    check("reset_cout", cout, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, o, co, ov, lat);
      if (lat >= LIMIT) check("vec_timeout", 1'b1, 1'b0);
      check($sformatf("vec%0d_latency", i), lat, N);
      check($sformatf("vec%0d_out", i), o, SAT ? vecs[i].o_sat : vecs[i].o);
      check($sformatf("vec%0d_cout", i), co, vecs[i].co);
      check($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
    end
    prev = o;

    // Early out_ready during CALC must be ignored; outputs hold the previous result.
    @(negedge clk);
    in1 = 16'h1234; in2 = 16'h1111; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      check("calc_out_held", out, prev);
      check("calc_out_valid_low", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    check("calc_out_held", out, prev);
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    check("hold_out_valid", out_valid, 1'b1);
    check("hold_out", out, 16'h2345);
    held = out;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = ~in_valid; in1 = 16'($urandom); in2 = 16'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      check("hold_out_stable", out, held);
      check("hold_in_ready_low", in_ready, 1'b0);
      check("hold_out_valid_high", out_valid, 1'b1);
    end
    // Handshake with in_valid high: the accept must wait for the next IDLE cycle.
    @(negedge clk);
    in_valid = 1'b1; in1 = 16'h4000; in2 = 16'h0003; sub = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("handshake_in_ready_next", in_ready, 1'b1);
    check("handshake_out_valid_low", out_valid, 1'b0);
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    check("no_same_cycle_accept_latency", lat, N + 1);
    model(16'h4000, 16'h0003, 1'b1, eo, eco, eov);
    check("reaccept_out", out, eo);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the second CALC cycle aborts the operation.
    run_op(16'h8000, 16'h0001, 1'b1, o, co, ov, lat);
    check("pre_reset_ovf", ov, 1'b1);
    @(negedge clk);
    in1 = 16'h0101; in2 = 16'h0202; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_out", out, 16'h0);
    check("abort_cout", cout, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      @(posedge clk); #1;
      check("abort_no_result", out_valid, 1'b0);
    end

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b;
      logic        s;
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      if (i % 8 == 0) a = 16'h7FFF;
      if (i % 8 == 1) a = 16'h8000;
      model(a, b, s, eo, eco, eov);
      run_op(a, b, s, o, co, ov, lat);
      if (lat != N) check("rand_latency", lat, N);
      check($sformatf("rand%0d_out", i), o, eo);
      check($sformatf("rand%0d_cout", i), co, eco);
      check($sformatf("rand%0d_ovf", i), ov, eov);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_add_sub.md
SEQ_ADD_SUB -- requirements
Module: seq_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands and mode presented.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have port in1, input, WIDTH, first operand.
REQ-008 SHALL have port in2, input, WIDTH, second operand.
REQ-009 SHALL have port sub, input, 1, 0 = in1+in2, 1 = in1-in2.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-012 SHALL have port out, output, WIDTH, result.
REQ-013 SHALL have port cout, output, 1, carry out of the MSB (for subtract: 1 = no borrow).
REQ-014 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL assert in_ready only in IDLE; accept occurs on a cycle with in_valid=1 and in_ready=1.
REQ-017 On accept, SHALL register in1, in2 XOR {WIDTH{sub}}, carry-in = sub, chunk index = 0, and go to CALC; in1/in2/sub SHALL be ignored on all other cycles.
REQ-018 In CALC, each cycle SHALL add chunk k (LSB first) of both registered operands plus the carry register, write the CHUNK-bit sum into result bits [k*CHUNK +: CHUNK], and update the carry.
REQ-019 After chunk N-1, SHALL go to DONE; out_valid SHALL rise exactly N cycles after the accept edge (N=1 gives 1-cycle latency).
REQ-020 SHALL compute cout as the final carry; ovf = (MSB a == MSB b') AND (MSB result != MSB a), where b' is the inverted-or-not second operand.
REQ-021 In DONE, out_valid=1; out, cout and ovf SHALL be held stable until out_ready=1.
REQ-022 On DONE with out_ready=1, SHALL go to IDLE; in_ready SHALL be 1 on the next cycle (no same-cycle re-accept).
REQ-023 out, cout and ovf SHALL hold the last result in IDLE and CALC; they SHALL change only on entry to DONE.
REQ-024 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, out=0, cout=0, ovf=0, and clear the carry register and chunk index.
REQ-026 Reset asserted during CALC or DONE SHALL abort the operation; no result SHALL be presented after reset is released.

Configuration
REQ-027 SHALL compile in signed saturation when macro SEQ_ADD_SUB_SAT_EN is defined: when ovf=1, out SHALL be clamped to 0x7F..F if MSB a = 0, otherwise to 0x80..0; ovf and cout SHALL still report the raw values.
REQ-028 When SEQ_ADD_SUB_SAT_EN is not defined, out SHALL be the wrapped WIDTH-bit result and no saturation logic SHALL be present.

Verification (WIDTH=16, CHUNK=4)
REQ-029 add 0x00FF+0x0F01 -> out=0x1000, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
REQ-030 add 0xFFFF+0x0001 -> out=0x0000, cout=1, ovf=0.
REQ-031 add 0x7FFF+0x0001 -> ovf=1, cout=0, out=0x8000 (0x7FFF with SEQ_ADD_SUB_SAT_EN).
REQ-032 sub 0x0005-0x0007 -> out=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> ovf=1, cout=1, out=0x7FFF (0x8000 with SAT).
REQ-033 out_ready held 0 for 3 cycles in DONE while in_valid toggles -> out stable, in_ready=0, no new accept; in_ready=1 the cycle after the out_ready handshake.
REQ-034 rst_n pulsed low during the 2nd CALC cycle -> all outputs 0 and in_ready=1 immediately; out_valid stays 0 until a new accept.
